// File: rtl/mem_access.sv
// Data-memory access stage: lw/sw over a req/ack bus, pass-through for other ops.
// Optional REQ timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ALUop_i,
    input  logic [31:0] MemAddr_i,
    input  logic [31:0] StoreData_i,
    input  logic [31:0] WriteData_i,
    input  logic [4:0]  WriteDataNum_i,
    input  logic        WriteReg_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        WriteReg_o,
    output logic [4:0]  WriteDataNum_o,
    output logic [31:0] WriteData_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [4:0] OP_LW = 5'b10100;
    localparam logic [4:0] OP_SW = 5'b10101;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [4:0]  num_q;
    logic [31:0] data_q;
    logic        wr_q;
    logic        misalign_q;
    logic        bus_err_q;

    logic        is_mem;
    logic        misaligned;
    logic        timeout_c;

    assign is_mem     = (ALUop_i == OP_LW) || (ALUop_i == OP_SW);
    assign misaligned = |MemAddr_i[1:0];

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access: TIMEOUT_CYCLES out of range 1..255");
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wait_cnt;

    // Counts unacknowledged REQ cycles; held at zero outside REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (state != REQ) begin
            wait_cnt <= 8'd0;
        end else if (!dmem_ack_i) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // An ack in the limit cycle takes priority over the abort
    assign timeout_c = (state == REQ) && !dmem_ack_i && ((wait_cnt + 8'd1) == LIMIT);
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        stall_o        = 1'b0;
        dmem_req_o     = 1'b0;
        WriteReg_o     = 1'b0;
        WriteDataNum_o = WriteDataNum_i;
        WriteData_o    = WriteData_i;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    stall_o   = 1'b1;
                    state_nxt = misaligned ? DONE : REQ;
                end else begin
                    WriteReg_o = WriteReg_i;
                end
            end
            REQ: begin
                stall_o    = 1'b1;
                dmem_req_o = 1'b1;
                if (dmem_ack_i || timeout_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                WriteReg_o     = wr_q;
                WriteDataNum_o = num_q;
                WriteData_o    = data_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset must silence handshake and write enables without waiting for a clock
        if (!rst_n) begin
            stall_o    = 1'b0;
            dmem_req_o = 1'b0;
            WriteReg_o = 1'b0;
        end
    end

    // Transaction latches and one-cycle DONE flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            num_q      <= 5'd0;
            data_q     <= 32'd0;
            wr_q       <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_q       <= 1'b0;
                    bus_err_q  <= 1'b0;
                    misalign_q <= 1'b0;
                    if (is_mem) begin
                        addr_q     <= MemAddr_i;
                        wdata_q    <= StoreData_i;
                        we_q       <= (ALUop_i == OP_SW);
                        num_q      <= WriteDataNum_i;
                        data_q     <= 32'd0;
                        misalign_q <= misaligned;
                    end
                end
                REQ: begin
                    if (dmem_ack_i) begin
                        data_q <= we_q ? 32'd0 : dmem_rdata_i;
                        wr_q   <= !we_q;
                    end else if (timeout_c) begin
                        data_q    <= 32'd0;
                        bus_err_q <= 1'b1;
                    end
                end
                default: begin
                    wr_q       <= 1'b0;
                    misalign_q <= 1'b0;
                    bus_err_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected write-back pushed at issue, popped in DONE.
module tb_mem_access;

    localparam logic [4:0] OP_LW  = 5'b10100;
    localparam logic [4:0] OP_SW  = 5'b10101;
    localparam logic [4:0] OP_ADD = 5'b00000;

    typedef struct {
        logic        wr;
        logic [4:0]  num;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  alu_op;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [31:0] write_data;
    logic [4:0]  write_num;
    logic        write_reg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        wr_out;
    logic [4:0]  num_out;
    logic [31:0] data_out;
    logic        misalign;
    logic        bus_err;

    int tests = 0;
    int fails = 0;
    wb_t sb[$];

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUop_i(alu_op), .MemAddr_i(mem_addr), .StoreData_i(store_data),
        .WriteData_i(write_data), .WriteDataNum_i(write_num), .WriteReg_i(write_reg),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata),
        .stall_o(stall), .WriteReg_o(wr_out), .WriteDataNum_o(num_out),
        .WriteData_o(data_out), .misalign_o(misalign), .bus_err_o(bus_err)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_nop(input logic [31:0] d, input logic [4:0] n, input logic w);
        alu_op = OP_ADD; mem_addr = 32'h0; store_data = 32'h0;
        write_data = d; write_num = n; write_reg = w;
    endtask

    // Drives one memory op through its whole life, starting in the current (IDLE) cycle
    task automatic do_mem(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] num, input int waits, input logic [31:0] rdata);
        wb_t e;
        wb_t got;
        logic is_sw;
        is_sw = (op == OP_SW);
        alu_op = op; mem_addr = addr; store_data = sdata; write_num = num;
        write_data = 32'hA5A5_0000; write_reg = 1'b1; dmem_ack = 1'b0;
        e.wr = !is_sw && (addr[1:0] == 2'b00);
        e.num = num;
        e.data = e.wr ? rdata : 32'h0;
        sb.push_back(e);
        #1;
        tests++;
        if (stall !== 1'b1 || dmem_req !== 1'b0 || wr_out !== 1'b0) begin
            fails++;
            $display("FAIL issue: stall=%b req=%b wr=%b required 1 0 0", stall, dmem_req, wr_out);
        end
        if (addr[1:0] == 2'b00) begin
            for (int i = 0; i <= waits; i++) begin
                cyc();
                if (i == waits) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end else begin
                    dmem_rdata = $urandom;
                end
                #1;
                tests++;
                if (dmem_req !== 1'b1 || stall !== 1'b1 || wr_out !== 1'b0 || dmem_we !== is_sw ||
                    dmem_addr !== addr || (is_sw && dmem_wdata !== sdata)) begin
                    fails++;
                    $display("FAIL req_phase: req=%b stall=%b wr=%b we=%b addr=%h wdata=%h required 1 1 0 %b %h %h",
                             dmem_req, stall, wr_out, dmem_we, dmem_addr, dmem_wdata, is_sw, addr, sdata);
                end
            end
        end
        cyc();
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        #1;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: queue empty at DONE");
        end else begin
            got.wr = wr_out; got.num = num_out; got.data = data_out;
            e = sb.pop_front();
            if (got.wr !== e.wr || got.num !== e.num || got.data !== e.data ||
                stall !== 1'b0 || dmem_req !== 1'b0 || bus_err !== 1'b0 ||
                misalign !== (addr[1:0] != 2'b00)) begin
                fails++;
                $display("FAIL done: wr=%b num=%0d data=%h stall=%b req=%b err=%b mis=%b required %b %0d %h 0 0 0 %b",
                         got.wr, got.num, got.data, stall, dmem_req, bus_err, misalign,
                         e.wr, e.num, e.data, (addr[1:0] != 2'b00));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        alu_op = OP_LW; mem_addr = 32'h40; store_data = 32'h0;
        write_data = 32'h1234_0000; write_num = 5'd9; write_reg = 1'b1;
        #3;
        tests++;
        if (stall !== 1'b0 || wr_out !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 ||
            dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || misalign !== 1'b0 || bus_err !== 1'b0 ||
            data_out !== 32'h1234_0000 || num_out !== 5'd9) begin
            fails++;
            $display("FAIL reset: stall=%b wr=%b req=%b we=%b addr=%h wdata=%h mis=%b err=%b data=%h num=%0d",
                     stall, wr_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, misalign, bus_err, data_out, num_out);
        end
        cyc(); cyc();
        drive_nop(32'h0, 5'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        cyc();
        drive_nop(32'd7, 5'd3, 1'b1);
        #1;
        tests++;
        if (wr_out !== 1'b1 || num_out !== 5'd3 || data_out !== 32'd7 || stall !== 1'b0 || dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL add: wr=%b num=%0d data=%h stall=%b req=%b required 1 3 7 0 0",
                     wr_out, num_out, data_out, stall, dmem_req);
        end
        for (int i = 0; i < 6; i++) begin
            logic [4:0] op;
            logic [31:0] d;
            logic [4:0] n;
            logic w;
            cyc();
            op = 5'($urandom_range(0, 19));
            d = $urandom; n = 5'($urandom); w = 1'($urandom);
            alu_op = op; write_data = d; write_num = n; write_reg = w;
            mem_addr = $urandom;
            #1;
            tests++;
            if (wr_out !== w || num_out !== n || data_out !== d || stall !== 1'b0 || dmem_req !== 1'b0) begin
                fails++;
                $display("FAIL nonmem_%0d: wr=%b num=%0d data=%h stall=%b required %b %0d %h 0",
                         i, wr_out, num_out, data_out, stall, w, n, d);
            end
        end
    endtask

    task automatic test_lw_wait();
        cyc();
        do_mem(OP_LW, 32'h10, 32'h0, 5'd5, 2, 32'hDEAD_BEEF);
    endtask

    task automatic test_sw();
        cyc();
        do_mem(OP_SW, 32'h20, 32'h1234_5678, 5'd6, 0, 32'hFFFF_FFFF);
    endtask

    task automatic test_misalign();
        cyc();
        do_mem(OP_LW, 32'h13, 32'h0, 5'd4, 0, 32'h0);
        cyc();
        drive_nop(32'h55, 5'd1, 1'b0);
        #1;
        tests++;
        if (misalign !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL misalign_clear: mis=%b stall=%b req=%b required 0 0 0", misalign, stall, dmem_req);
        end
    endtask

    task automatic test_long_wait();
`ifdef MEM_TIMEOUT_EN
        cyc();
        alu_op = OP_LW; mem_addr = 32'h80; write_num = 5'd7; write_reg = 1'b1; dmem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            tests++;
            if (dmem_req !== 1'b1 || stall !== 1'b1) begin
                fails++;
                $display("FAIL timeout_req_%0d: req=%b stall=%b required 1 1", i, dmem_req, stall);
            end
        end
        cyc();
        #1;
        tests++;
        if (bus_err !== 1'b1 || wr_out !== 1'b0 || data_out !== 32'h0 || dmem_req !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL timeout_done: err=%b wr=%b data=%h req=%b stall=%b required 1 0 0 0 0",
                     bus_err, wr_out, data_out, dmem_req, stall);
        end
        cyc();
        drive_nop(32'h9, 5'd2, 1'b1);
        #1;
        tests++;
        if (bus_err !== 1'b0 || stall !== 1'b0 || wr_out !== 1'b1) begin
            fails++;
            $display("FAIL timeout_idle: err=%b stall=%b wr=%b required 0 0 1", bus_err, stall, wr_out);
        end
        cyc();
        do_mem(OP_LW, 32'h84, 32'h0, 5'd8, 3, 32'hCAFE_F00D);
`else
        cyc();
        do_mem(OP_LW, 32'h84, 32'h0, 5'd8, 9, 32'hCAFE_F00D);
`endif
    endtask

    task automatic test_reset_mid();
        cyc();
        alu_op = OP_LW; mem_addr = 32'h30; write_num = 5'd11; write_reg = 1'b1; dmem_ack = 1'b0;
        cyc();
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || wr_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: req=%b stall=%b wr=%b required 0 0 0", dmem_req, stall, wr_out);
        end
        cyc();
        drive_nop(32'h0, 5'd11, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            dmem_ack = (i < 2);
            dmem_rdata = 32'hBAD0_BAD0;
            #1;
            tests++;
            if (wr_out !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
                fails++;
                $display("FAIL stray_ack_%0d: wr=%b stall=%b req=%b required 0 0 0", i, wr_out, stall, dmem_req);
            end
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [4:0] op;
            logic [31:0] a;
            op = $urandom_range(0, 1) ? OP_SW : OP_LW;
            a = {$urandom_range(0, 255), 2'b00};
            if (i == 5) a[0] = 1'b1;
            cyc();
            do_mem(op, a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom);
        end
        cyc();
        drive_nop(32'h77, 5'd12, 1'b1);
        #1;
        tests++;
        if (sb.size() != 0 || stall !== 1'b0 || wr_out !== 1'b1 || data_out !== 32'h77) begin
            fails++;
            $display("FAIL b2b_end: left=%0d stall=%b wr=%b data=%h required 0 0 1 77",
                     sb.size(), stall, wr_out, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lw_wait();
        test_sw();
        test_misalign();
        test_long_wait();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
